// File: rtl/snn_config_loader.sv
// snn_config_loader: byte-serial loader for SNN parameter registers.
//
// A frame is one header byte {start_addr[3:0], n_minus_1[3:0]} followed by N data bytes.
// Each data byte is registered and then written out during a single WRITE cycle. The
// address auto-increments modulo 16. Writes aimed at address 15 are suppressed and flag
// addr_err. A stalled frame is aborted after TIMEOUT idle cycles.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   rx_data/valid/ready   - incoming byte stream (valid/ready handshake)
//   addr, data_out        - parameter write address and data
//   write_enable          - one-cycle write strobe
//   err_clear             - clears the sticky addr_err flag
//   busy                  - a frame is in progress
//   frame_done            - pulses in the WRITE cycle of the last byte of a frame
//   timeout_err           - pulses for one cycle after a frame is aborted
//   addr_err              - sticky: a byte targeted address 15
module snn_config_loader #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [3:0] addr,
    output logic [7:0] data_out,
    output logic       write_enable,
    input  logic       err_clear,
    output logic       busy,
    output logic       frame_done,
    output logic       timeout_err,
    output logic       addr_err
);

    localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StData  = 2'd1,
        StWrite = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  addr_q, addr_d;
    logic [3:0]  count_q, count_d;   // data bytes still to come after the current one
    logic [7:0]  data_q, data_d;
    logic [15:0] idle_q, idle_d;
    logic        addr_err_q, addr_err_d;
    logic        timeout_q, timeout_d;
    logic        accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= 4'd0;
            count_q    <= 4'd0;
            data_q     <= 8'd0;
            idle_q     <= 16'd0;
            addr_err_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            idle_q     <= idle_d;
            addr_err_q <= addr_err_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        count_d      = count_q;
        data_d       = data_q;
        idle_d       = idle_q;
        addr_err_d   = addr_err_q;
        timeout_d    = 1'b0;
        rx_ready     = 1'b0;
        busy         = 1'b0;
        write_enable = 1'b0;
        frame_done   = 1'b0;

        // Clear first so a same-cycle set below takes priority.
        if (err_clear) begin
            addr_err_d = 1'b0;
        end

        // Held low during reset so nothing is handshaken while the block is being cleared.
        rx_ready = !reset && (state_q != StWrite);
        accept   = rx_valid && rx_ready;

        unique case (state_q)
            StIdle: begin
                idle_d = 16'd0;
                if (accept) begin
                    addr_d  = rx_data[7:4];
                    count_d = rx_data[3:0];
                    state_d = StData;
                end
            end
            StData: begin
                busy = 1'b1;
                if (accept) begin
                    data_d  = rx_data;
                    idle_d  = 16'd0;
                    state_d = StWrite;
                end else begin
                    idle_d = idle_q + 16'd1;
                    if (idle_d == TimeoutVal) begin
                        state_d   = StIdle;
                        timeout_d = 1'b1;
                    end
                end
            end
            StWrite: begin
                busy         = 1'b1;
                write_enable = (addr_q != 4'hF);
                frame_done   = (count_q == 4'd0);
                if (addr_q == 4'hF) begin
                    addr_err_d = 1'b1;
                end
                addr_d = addr_q + 4'd1;
                idle_d = 16'd0;
                if (count_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    count_d = count_q - 4'd1;
                    state_d = StData;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign addr        = addr_q;
    assign data_out    = data_q;
    assign timeout_err = timeout_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_snn_config_loader.sv
// Directed testbench for snn_config_loader with hand-computed expectations.
module tb_snn_config_loader;

    localparam int unsigned T = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [3:0] addr;
    logic [7:0] data_out;
    logic       write_enable;
    logic       err_clear = 1'b0;
    logic       busy;
    logic       frame_done;
    logic       timeout_err;
    logic       addr_err;

    snn_config_loader #(.TIMEOUT(T)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .addr         (addr),
        .data_out     (data_out),
        .write_enable (write_enable),
        .err_clear    (err_clear),
        .busy         (busy),
        .frame_done   (frame_done),
        .timeout_err  (timeout_err),
        .addr_err     (addr_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [11:0] wlog[$];
    int          wcyc[$];
    int          fd_cnt = 0;
    logic [3:0]  fd_addr = 4'd0;
    int          te_cnt = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (write_enable) begin
            wlog.push_back({addr, data_out});
            wcyc.push_back(cyc);
        end
        if (frame_done) begin
            fd_cnt++;
            fd_addr = addr;
        end
        if (timeout_err) te_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wlog.delete();
        wcyc.delete();
        fd_cnt = 0;
        te_cnt = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present a byte at a cycle boundary and hold it until it is accepted.
    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_accepted", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic check_write(input string tag, input int idx, input logic [11:0] exp);
        if (idx < wlog.size()) check(tag, 32'(wlog[idx]), 32'(exp));
        else check(tag, 32'hdead, 32'(exp));
    endtask

    logic [7:0] arr[6];
    int idx, iters, lows;
    bit r;

    initial begin
        // Reset behaviour
        wait_cycles(2);
        check("rdy_in_reset", 32'(rx_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_outs", 32'({addr, data_out, write_enable, busy, frame_done, timeout_err,
                               addr_err}), 32'd0);
        check("rdy_after_rst", 32'(rx_ready), 32'd1);

        // Basic three-byte frame from address 0
        clear_logs();
        send(8'h02);
        send(8'h80);
        send(8'h05);
        send(8'h02);
        wait_cycles(3);
        check("f1_nwrites", 32'(wlog.size()), 32'd3);
        check_write("f1_w0", 0, {4'd0, 8'h80});
        check_write("f1_w1", 1, {4'd1, 8'h05});
        check_write("f1_w2", 2, {4'd2, 8'h02});
        check("f1_fd_cnt", 32'(fd_cnt), 32'd1);
        check("f1_fd_addr", 32'(fd_addr), 32'd2);
        check("f1_busy", 32'(busy), 32'd0);

        // Frame running into address 15
        clear_logs();
        send(8'hE1);
        send(8'h11);
        send(8'h22);
        wait_cycles(3);
        check("f2_nwrites", 32'(wlog.size()), 32'd1);
        check_write("f2_w0", 0, {4'd14, 8'h11});
        check("f2_addr_err", 32'(addr_err), 32'd1);
        check("f2_fd_cnt", 32'(fd_cnt), 32'd1);
        wait_cycles(5);
        check("f2_err_sticky", 32'(addr_err), 32'd1);
        @(posedge clk);
        #1;
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        @(negedge clk);
        check("f2_err_cleared", 32'(addr_err), 32'd0);

        // Timeout after one write, stall boundary
        clear_logs();
        send(8'h31);
        send(8'hAA);
        wait_cycles(T + 1);
        check("to_busy_before", 32'(busy), 32'd1);
        check("to_no_pulse_yet", 32'(timeout_err), 32'd0);
        @(negedge clk);
        check("to_busy_after", 32'(busy), 32'd0);
        check("to_pulse", 32'(timeout_err), 32'd1);
        wait_cycles(3);
        check("to_te_cnt", 32'(te_cnt), 32'd1);
        check("to_fd_cnt", 32'(fd_cnt), 32'd0);
        check("to_nwrites", 32'(wlog.size()), 32'd1);
        check_write("to_w0", 0, {4'd3, 8'hAA});
        send(8'h50);
        send(8'h77);
        wait_cycles(3);
        check("to_hdr_w", 32'(wlog.size()), 32'd2);
        check_write("to_w1", 1, {4'd5, 8'h77});
        check("to_hdr_fd", 32'(fd_cnt), 32'd1);

        // Back-to-back frame with rx_valid held high
        clear_logs();
        arr[0] = 8'h04;
        arr[1] = 8'hA0;
        arr[2] = 8'hA1;
        arr[3] = 8'hA2;
        arr[4] = 8'hA3;
        arr[5] = 8'hA4;
        @(posedge clk);
        #1;
        idx = 0;
        iters = 0;
        lows = 0;
        rx_data  = arr[0];
        rx_valid = 1'b1;
        while (idx < 6 && iters < 30) begin
            @(negedge clk);
            r = rx_ready;
            iters++;
            if (!r) lows++;
            @(posedge clk);
            #1;
            if (r) begin
                idx++;
                if (idx < 6) rx_data = arr[idx];
            end
        end
        rx_valid = 1'b0;
        wait_cycles(3);
        check("bb_iters", 32'(iters), 32'd10);
        check("bb_lows", 32'(lows), 32'd4);
        check("bb_nwrites", 32'(wlog.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check_write("bb_w", i, {4'(i), 8'hA0 + 8'(i)});
            if (i > 0 && i < wcyc.size()) check("bb_spacing", 32'(wcyc[i] - wcyc[i-1]), 32'd2);
        end
        check("bb_fd_cnt", 32'(fd_cnt), 32'd1);

        // Reset in the middle of a frame
        clear_logs();
        send(8'h02);
        send(8'h11);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("mr_rdy_in_reset", 32'(rx_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mr_outs", 32'({addr, data_out, write_enable, busy, frame_done, timeout_err,
                              addr_err}), 32'd0);
        wait_cycles(5);
        check("mr_nwrites", 32'(wlog.size()), 32'd1);
        check_write("mr_w0", 0, {4'd0, 8'h11});
        check("mr_no_pulses", 32'(fd_cnt + te_cnt), 32'd0);
        send(8'h10);
        send(8'h33);
        wait_cycles(3);
        check("mr_hdr_w", 32'(wlog.size()), 32'd2);
        check_write("mr_w1", 1, {4'd1, 8'h33});

        // Wrap from 15 to 0, clear asserted in the same cycle as the set
        clear_logs();
        send(8'hF1);
        send(8'h01);
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        @(negedge clk);
        check("wr_set_wins", 32'(addr_err), 32'd1);
        send(8'h02);
        wait_cycles(3);
        check("wr_nwrites", 32'(wlog.size()), 32'd1);
        check_write("wr_w0", 0, {4'd0, 8'h02});
        check("wr_addr_err", 32'(addr_err), 32'd1);
        check("wr_fd_addr", 32'(fd_addr), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/snn_config_loader.md
SNN_CONFIG_LOADER -- requirements
Module: snn_config_loader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: idle cycles allowed between bytes inside a frame before the frame is aborted (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port rx_data, input, 8 bits: incoming configuration byte.
REQ-005 SHALL have port rx_valid, input, 1 bit: rx_data is valid.
REQ-006 SHALL have port rx_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-007 SHALL have port addr, output, 4 bits: parameter write address.
REQ-008 SHALL have port data_out, output, 8 bits: parameter write data.
REQ-009 SHALL have port write_enable, output, 1 bit: one-cycle parameter write strobe.
REQ-010 SHALL have port err_clear, input, 1 bit: clears addr_err.
REQ-011 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of a frame.
REQ-013 SHALL have port timeout_err, output, 1 bit: one-cycle pulse when a frame is aborted.
REQ-014 SHALL have port addr_err, output, 1 bit: sticky flag set when a byte targets address 15.

Function
REQ-015 A byte SHALL be accepted on a rising edge where rx_valid and rx_ready are both 1.
REQ-016 Frame format SHALL be one header byte followed by N data bytes.
REQ-017 Header bits [7:4] SHALL give the start address; header bits [3:0] SHALL give N-1, so N is 1..16.
REQ-018 The FSM SHALL have three states: IDLE, DATA and WRITE.
REQ-019 In IDLE, rx_ready=1 and busy=0; an accepted byte SHALL load the start address and remaining count, then go to DATA.
REQ-020 In DATA, rx_ready=1 and busy=1; an accepted byte SHALL be registered into data_out, then go to WRITE.
REQ-021 In WRITE, rx_ready=0 and busy=1; write_enable SHALL be 1 for exactly this one cycle, with addr and data_out stable.
REQ-022 Latency SHALL be: data byte accepted at edge k -> write_enable high during the cycle after edge k.
REQ-023 Throughput SHALL be at most one data byte per two cycles.
REQ-024 On leaving WRITE, addr SHALL increment modulo 16 and the remaining count SHALL decrement; the FSM goes to DATA if the count is nonzero, otherwise to IDLE.
REQ-025 frame_done SHALL pulse in the WRITE cycle of the last byte of a frame.
REQ-026 A WRITE cycle whose addr is 15 SHALL keep write_enable=0, still consume the byte, and set addr_err.
REQ-027 After an address wrap 15 -> 0, writes to addresses 0 and above SHALL be performed normally.
REQ-028 addr_err SHALL stay set until err_clear=1; if a set and err_clear=1 occur in the same cycle, the set SHALL win.
REQ-029 A 16-bit idle counter SHALL clear on every accepted byte and on entry to DATA, and SHALL increment in each DATA cycle with no handshake.
REQ-030 When the idle counter reaches TIMEOUT, the FSM SHALL go to IDLE, timeout_err SHALL pulse for one cycle, no write SHALL occur, and frame_done SHALL stay 0.
REQ-031 The byte accepted after a timeout SHALL be treated as a header.
REQ-032 The idle counter SHALL NOT run in IDLE or WRITE.
REQ-033 rx_valid SHALL be ignored while rx_ready=0; the source holds its byte until it is accepted.

Reset
REQ-034 While reset=1 on a rising edge, the FSM SHALL go to IDLE and the counters and addr_err SHALL clear.
REQ-035 After that edge, addr=0, data_out=0, write_enable=0, busy=0, frame_done=0, timeout_err=0 and addr_err=0.
REQ-036 rx_ready SHALL be 0 while reset=1 and 1 in the first cycle after reset is released.
REQ-037 Reset in the middle of a frame SHALL discard the partial frame with no further writes and no pulses.

Verification
REQ-038 The bench SHALL check: header 0x02, then 0x80, 0x05, 0x02 -> writes (0,0x80), (1,0x05), (2,0x02); frame_done pulses with the third write; busy falls afterwards.
REQ-039 The bench SHALL check: header 0xE1, then 0x11, 0x22 -> write (14,0x11); 0x22 consumed with no write; addr_err=1 and stays 1 until err_clear; frame_done still pulses.
REQ-040 The bench SHALL check: header 0x31, then 0xAA, then a stall of TIMEOUT cycles -> write (3,0xAA); one timeout_err pulse; return to IDLE; next byte 0x50 treated as a header (addr 5, N=1).
REQ-041 The bench SHALL check: rx_valid held at 1 with a 5-byte frame -> rx_ready toggles 1/0 and write_enable fires every second cycle at addresses 0..4 in order.
REQ-042 The bench SHALL check: header 0x02 and one data byte written, then reset pulsed -> all outputs 0, no further write; next byte 0x10 treated as a header.
REQ-043 The bench SHALL check: header 0xF1, then 0x01, 0x02 -> no write at address 15 and addr_err=1; write (0,0x02) performed after the wrap.
